button_events: RTL and testbench
================================

# button_events

Button event generator placed directly downstream of the debouncer. It consumes the debouncer's clean level output and turns it into discrete PRESS, RELEASE, LONG and REPEAT events. Events are queued in a small show-ahead FIFO and drained by the consumer (CPU/MMIO or UI logic) over a valid/ready handshake.

## Interface
- TICKBITS, default 10: hold-time prescaler; one tick every 2^TICKBITS clk cycles.
- CNTBITS, default 8: width of the tick counter.
- LONG_TICKS, default 100: ticks from PRESS to LONG; legal range 1..2^CNTBITS-1.
- REPEAT_TICKS, default 20: ticks between REPEAT events; legal range 1..2^CNTBITS-1.
- DEPTHBITS, default 2: FIFO depth is 2^DEPTHBITS entries.

Ports:
- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  reset; asynchronous assert, active-low.
- in  in  1  debounced button level; synchronous to clk.
- ev_valid  out  1  FIFO head holds an event.
- ev_code  out  2  head event: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- ev_ready  in  1  consumer pops the head when high together with ev_valid.
- held  out  1  button currently considered pressed.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

## Operation
- in_d holds `in` delayed by one clk. rise = in & ~in_d; fall = ~in & in_d.
- The prescaler precnt (TICKBITS wide) is free-running. tick = &precnt. precnt is set to 0 on every rise accepted in IDLE.
- FSM states: IDLE, PRESSED, LONG_HELD. held = (state != IDLE), registered.
- IDLE:
  - On rise: push PRESS, holdcnt<=0, go to PRESSED.
  - fall is ignored.
- PRESSED:
  - On fall: push RELEASE, go to IDLE.
  - Else on tick with holdcnt==LONG_TICKS-1: push LONG, holdcnt<=0, go to LONG_HELD.
  - Else on tick: holdcnt++.
- LONG_HELD:
  - On fall: push RELEASE, go to IDLE.
  - Ticks are handled as described under Configuration.
- fall has priority over tick in the same cycle. A tick is never lost on another cycle.
- FIFO:
  - ev_valid = not empty; ev_code = head entry (show-ahead).
  - Pop on ev_valid & ev_ready.
  - Push when not full is accepted.
  - Push when full with a pop in the same cycle is accepted; count is unchanged.
  - Push when full without a pop is dropped and overflow<=1.
- overflow: ovf_clr clears it. If a drop and ovf_clr occur in the same cycle, the set wins.
- Pointers wrap modulo 2^DEPTHBITS. A count of DEPTHBITS+1 bits distinguishes full from empty.

## Timing
- Reset values: state=IDLE, in_d=1 (a button already high at reset produces no PRESS), precnt=0, holdcnt=0, FIFO empty, ev_valid=0, ev_code=0, held=0, overflow=0.
- Event latency: `in` changes before edge E. At E the event is pushed and held updates. ev_valid is high after E, i.e. 1 cycle.
- Event timing, with the press accepted at edge E0:
  - LONG is pushed at E0 + LONG_TICKS·2^TICKBITS.
  - Each REPEAT follows the previous LONG/REPEAT by REPEAT_TICKS·2^TICKBITS.
- Pop takes effect at the edge where ev_valid & ev_ready. The next entry, or ev_valid=0, appears after that edge.
- Reset asserted mid-operation immediately returns everything to reset values. Queued events are discarded.

## Configuration
- BUTTON_EVENTS_AUTOREPEAT_EN defined: in LONG_HELD, a tick with holdcnt==REPEAT_TICKS-1 pushes REPEAT and sets holdcnt<=0. Any other tick increments holdcnt.
- Macro undefined: LONG_HELD ignores ticks, code 3 is never produced, and REPEAT_TICKS is unused. The remaining behaviour is identical.

## Test plan
Test parameters: TICKBITS=2, LONG_TICKS=3, REPEAT_TICKS=2, DEPTHBITS=2, ev_ready=1 unless stated.
- Short press: in high for 5 cycles then low -> PRESS 1 cycle after rise, RELEASE 1 cycle after fall, no LONG, held high for exactly 5 cycles.
- Long hold with macro defined: in high 40 cycles -> PRESS, then LONG 12 cycles after the press edge, REPEAT at +8, +16, +24 after LONG, then RELEASE. Without the macro the REPEATs are absent.
- Overflow: ev_ready=0, produce 5 events -> 4 queued in order PRESS/RELEASE/PRESS/RELEASE, 5th dropped, overflow=1. Raise ovf_clr -> overflow=0.
- Full FIFO plus push plus pop in the same cycle -> count stays 4, no overflow, new event at the tail.
- Reset: in=1 during and after reset -> no PRESS. Reset asserted while in LONG_HELD with 3 events queued -> ev_valid=0, held=0 asynchronously.

Source files
------------

// File: rtl/button_events.sv
// button_events: turns a debounced button level into PRESS / RELEASE / LONG /
// REPEAT events, queued in a small show-ahead FIFO drained by valid/ready.
//
// Optional feature: define BUTTON_EVENTS_AUTOREPEAT_EN to emit REPEAT events
// while the button stays held after LONG. Without it LONG_HELD ignores ticks.
//
// Ports:
//   clk       clock, rising edge
//   n_rst     asynchronous active-low reset
//   in        debounced button level, synchronous to clk
//   ev_valid  FIFO head holds an event
//   ev_code   head event: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   ev_ready  consumer pops the head when high with ev_valid
//   held      button currently considered pressed
//   overflow  sticky: an event was dropped on a full FIFO
//   ovf_clr   clears overflow (a same-cycle drop wins)
module button_events #(
  parameter int TICKBITS     = 10,
  parameter int CNTBITS      = 8,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int DEPTHBITS    = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       held,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int DEPTH = 1 << DEPTHBITS;
  localparam logic [DEPTHBITS:0]  DEPTH_CNT = (DEPTHBITS+1)'(DEPTH);
  localparam logic [CNTBITS-1:0]  LONG_LAST = CNTBITS'(LONG_TICKS - 1);
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
  localparam logic [CNTBITS-1:0]  REPEAT_LAST = CNTBITS'(REPEAT_TICKS - 1);
`endif

  // Elaboration-time legality checks on the hold-time parameters.
  if (LONG_TICKS < 1 || LONG_TICKS > (1 << CNTBITS) - 1) begin : g_bad_long
    $error("button_events: LONG_TICKS out of range");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > (1 << CNTBITS) - 1) begin : g_bad_repeat
    $error("button_events: REPEAT_TICKS out of range");
  end

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;
  typedef enum logic [1:0] {EV_PRESS = 2'd0, EV_RELEASE = 2'd1,
                            EV_LONG = 2'd2, EV_REPEAT = 2'd3} ev_t;

  state_t               state, state_next;
  logic                 in_d;
  logic [TICKBITS-1:0]  precnt;
  logic [CNTBITS-1:0]   holdcnt, holdcnt_next;
  logic                 rise, fall, tick;
  logic                 push, precnt_clr;
  ev_t                  push_code;

  logic [1:0]           mem [DEPTH];
  logic [DEPTHBITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTHBITS:0]   count;
  logic                 full, pop, accept, drop;

  assign rise = in & ~in_d;
  assign fall = ~in & in_d;
  assign tick = &precnt;

  always_comb begin
    state_next   = state;
    holdcnt_next = holdcnt;
    push         = 1'b0;
    push_code    = EV_PRESS;
    precnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          push         = 1'b1;
          push_code    = EV_PRESS;
          holdcnt_next = '0;
          precnt_clr   = 1'b1;
          state_next   = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          push       = 1'b1;
          push_code  = EV_RELEASE;
          state_next = IDLE;
        end else if (tick) begin
          if (holdcnt == LONG_LAST) begin
            push         = 1'b1;
            push_code    = EV_LONG;
            holdcnt_next = '0;
            state_next   = LONG_HELD;
          end else begin
            holdcnt_next = holdcnt + 1'b1;
          end
        end
      end
      LONG_HELD: begin
        if (fall) begin
          push       = 1'b1;
          push_code  = EV_RELEASE;
          state_next = IDLE;
        end
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        else if (tick) begin
          if (holdcnt == REPEAT_LAST) begin
            push         = 1'b1;
            push_code    = EV_REPEAT;
            holdcnt_next = '0;
          end else begin
            holdcnt_next = holdcnt + 1'b1;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      in_d    <= 1'b1;
      precnt  <= '0;
      holdcnt <= '0;
      held    <= 1'b0;
    end else begin
      state   <= state_next;
      in_d    <= in;
      precnt  <= precnt_clr ? '0 : precnt + 1'b1;
      holdcnt <= holdcnt_next;
      held    <= (state_next != IDLE);
    end
  end

  // A push into a full FIFO still fits when the head is popped the same cycle.
  assign full     = (count == DEPTH_CNT);
  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  assign accept   = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign ev_code  = ev_valid ? mem[rd_ptr] : 2'd0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

  localparam int TB_TICKBITS = 2;
  localparam int TB_LONG     = 3;
  localparam int TB_REPEAT   = 2;
  localparam int TB_DEPTH    = 4;
  localparam int PERIOD_CYC  = 1 << TB_TICKBITS;
  localparam int LONG_CYC    = TB_LONG * PERIOD_CYC;
  localparam int REP_CYC     = TB_REPEAT * PERIOD_CYC;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       btn;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic       held;
  logic       overflow;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  button_events #(
    .TICKBITS    (TB_TICKBITS),
    .CNTBITS     (8),
    .LONG_TICKS  (TB_LONG),
    .REPEAT_TICKS(TB_REPEAT),
    .DEPTHBITS   (2)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .in      (btn),
    .ev_valid(ev_valid),
    .ev_code (ev_code),
    .ev_ready(ev_ready),
    .held    (held),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: event times derived from the press timestamp, FIFO as a queue.
  logic [1:0] q[$];
  bit         m_pressed;
  int         m_press_t;
  bit         m_prev_in;
  bit         m_ovf;
  int         t;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pressed = 0;
    m_press_t = 0;
    m_prev_in = 1;
    m_ovf     = 0;
  endtask

  task automatic model_step();
    bit rise, fall, push, pop;
    logic [1:0] code;
    int d;
    push = 0;
    code = 2'd0;
    rise = btn && !m_prev_in;
    fall = !btn && m_prev_in;
    if (!m_pressed) begin
      if (rise) begin
        push = 1; code = 2'd0; m_pressed = 1; m_press_t = t;
      end
    end else if (fall) begin
      push = 1; code = 2'd1; m_pressed = 0;
    end else begin
      d = t - m_press_t;
      if (d == LONG_CYC) begin
        push = 1; code = 2'd2;
      end
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      else if (d > LONG_CYC && ((d - LONG_CYC) % REP_CYC) == 0) begin
        push = 1; code = 2'd3;
      end
`endif
    end
    pop = (q.size() != 0) && ev_ready;
    if (push && q.size() == TB_DEPTH && !pop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (push && q.size() < TB_DEPTH) q.push_back(code);
    m_prev_in = btn;
    t++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ev_valid"}, 8'(ev_valid), 8'(q.size() != 0));
    check({tag, ".ev_code"},  8'(ev_code),  8'((q.size() != 0) ? q[0] : 2'd0));
    check({tag, ".held"},     8'(held),     8'(m_pressed));
    check({tag, ".overflow"}, 8'(overflow), 8'(m_ovf));
  endtask

  task automatic step(input string tag, input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ev_valid"}, 8'(ev_valid), 8'd0);
    check({tag, ".ev_code"},  8'(ev_code),  8'd0);
    check({tag, ".held"},     8'(held),     8'd0);
    check({tag, ".overflow"}, 8'(overflow), 8'd0);
  endtask

  initial begin
    n_rst    = 1'b0;
    btn      = 1'b1;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    t        = 0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Button already high at reset: no PRESS.
    step("high_at_reset", 6);
    btn = 1'b0;
    step("idle", 4);

    // Short press.
    btn = 1'b1;
    step("short_press", 5);
    btn = 1'b0;
    step("short_release", 4);

    // Long hold with optional auto-repeat.
    btn = 1'b1;
    step("long_hold", 40);
    btn = 1'b0;
    step("long_release", 4);

    // Overflow: five events with the consumer stalled.
    ev_ready = 1'b0;
    btn = 1'b1; step("ovf_fill", 2);
    btn = 1'b0; step("ovf_fill", 2);
    btn = 1'b1; step("ovf_fill", 2);
    btn = 1'b0; step("ovf_fill", 2);
    btn = 1'b1; step("ovf_drop", 2);
    check("ovf_set", 8'(overflow), 8'd1);
    ovf_clr = 1'b1; step("ovf_clr", 1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 8'(overflow), 8'd0);

    // Full FIFO: push and pop on the same edge.
    ev_ready = 1'b1;
    btn = 1'b0;
    step("full_push_pop", 1);
    ev_ready = 1'b0;
    step("full_after", 2);
    check("full_no_ovf", 8'(overflow), 8'd0);

    // Drop and clear on the same edge: set wins.
    btn = 1'b1; ovf_clr = 1'b1;
    step("ovf_set_wins", 1);
    ovf_clr = 1'b0;
    check("ovf_set_wins_val", 8'(overflow), 8'd1);
    ovf_clr = 1'b1; btn = 1'b0; ev_ready = 1'b1;
    step("drain", 1);
    ovf_clr = 1'b0;
    step("drain", 6);

    // Randomized phase.
    for (int k = 0; k < 60; k++) begin
      int hold;
      btn = ~btn;
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        ev_ready = ($urandom_range(0, 3) != 0);
        ovf_clr  = ($urandom_range(0, 15) == 0);
        step("random", 1);
      end
    end
    ev_ready = 1'b1; ovf_clr = 1'b1; btn = 1'b0;
    step("random_drain", 8);
    ovf_clr = 1'b0;

    // Reset while in LONG_HELD with three events queued.
    ev_ready = 1'b0;
    btn = 1'b1; step("pre_rst", 2);
    btn = 1'b0; step("pre_rst", 2);
    btn = 1'b1; step("pre_rst", 14);
    ev_ready = 1'b1; step("pre_rst_pop", 1);
    ev_ready = 1'b0; step("pre_rst", 1);
    check("pre_rst_queued", 8'(q.size()), 8'd3);
    check("pre_rst_held", 8'(held), 8'd1);
    #1;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    check_reset_values("in_reset");
    n_rst = 1'b1;
    step("after_reset_high", 6);
    btn = 1'b0; ev_ready = 1'b1;
    step("after_reset", 3);
    btn = 1'b1;
    step("after_reset_press", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
